bcp_engine: RTL and testbench

- Boolean Constraint Propagation responder for the DPLL control FSM.
- On `start` with a newly assigned variable, it walks that variable's occurrence range in the clause store and evaluates each clause against the variable state table.
- Each unit literal it finds is pushed onto the imply stack. The engine is the writer side of the imply stack that control pops in FIND_NEXT.
- It ends each run with a `done` pulse; a falsified clause also raises `conflict`.

---
 rtl/sat_pkg.sv | 24 ++
 rtl/clause_eval.sv | 35 +++
 rtl/bcp_engine.sv | 141 ++++++++++++++
 tb/tb_bcp_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared constants and clause/literal types for the SAT solver datapath.
package sat_pkg;
  localparam int NUM_VARIABLE   = 128;
  localparam int VARIABLE_INDEX = 7;
  localparam int VAR_PER_CLAUSE = 5;
  localparam int OCC_INDEX      = 10;
  localparam int LIT_W          = VARIABLE_INDEX + 2;
  localparam int CLAUSE_W       = VAR_PER_CLAUSE * LIT_W;

  typedef struct packed {
    logic                      valid;
    logic                      polarity;
    logic [VARIABLE_INDEX-1:0] var_id;
  } literal_t;

  typedef literal_t [VAR_PER_CLAUSE-1:0] clause_t;

  localparam logic TYPE_D = 1'b0;
  localparam logic TYPE_F = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_RANGE, S_LOAD, S_READ, S_EVAL, S_PUSH, S_DONE
  } bcp_state_e;
endpackage

// File: rtl/clause_eval.sv
// Combinational clause classifier: satisfied flag, open-literal count
// (saturating at 2) and the first open literal for unit propagation.
module clause_eval
  import sat_pkg::*;
(
  input  clause_t                   clause,
  input  logic [NUM_VARIABLE-1:0]   var_assigned,
  input  logic [NUM_VARIABLE-1:0]   var_value,
  output logic                      satisfied,
  output logic [1:0]                open_count,
  output logic [VARIABLE_INDEX-1:0] unit_var,
  output logic                      unit_val
);

  always_comb begin
    satisfied  = 1'b0;
    open_count = 2'd0;
    unit_var   = '0;
    unit_val   = 1'b0;
    for (int unsigned i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (clause[i].valid) begin
        if (var_assigned[clause[i].var_id]) begin
          if (var_value[clause[i].var_id] == clause[i].polarity) satisfied = 1'b1;
        end else begin
          if (open_count == 2'd0) begin
            unit_var = clause[i].var_id;
            unit_val = clause[i].polarity;
          end
          if (open_count != 2'd2) open_count = open_count + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcp_engine.sv
// Boolean constraint propagation: walks a variable's occurrence range,
// pushes unit implications onto the imply stack and flags conflicts.
module bcp_engine
  import sat_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [VARIABLE_INDEX-1:0] prop_var,
  output logic                      busy,
  output logic                      done,
  output logic                      conflict,
  output logic [VARIABLE_INDEX-1:0] range_addr,
  input  logic [OCC_INDEX-1:0]      range_start,
  input  logic [OCC_INDEX-1:0]      range_end,
  output logic [OCC_INDEX-1:0]      clause_addr,
  input  logic [CLAUSE_W-1:0]       clause_data,
  input  logic [NUM_VARIABLE-1:0]   var_assigned,
  input  logic [NUM_VARIABLE-1:0]   var_value,
  output logic                      push_imply,
  output logic [VARIABLE_INDEX-1:0] imply_var,
  output logic                      imply_val,
  output logic                      imply_type,
  input  logic                      full_imply
);

  localparam int IDX_W = OCC_INDEX + 1;

  bcp_state_e                state_q, state_d;
  logic [VARIABLE_INDEX-1:0] prop_var_q, prop_var_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          end_q, end_d;
  logic                      conflict_q, conflict_d;
  logic [VARIABLE_INDEX-1:0] imply_var_q, imply_var_d;
  logic                      imply_val_q, imply_val_d;

  logic                      sat_w;
  logic [1:0]                open_w;
  logic [VARIABLE_INDEX-1:0] unit_var_w;
  logic                      unit_val_w;
  logic [IDX_W-1:0]          idx_inc;

  clause_eval u_eval (
    .clause       (clause_t'(clause_data)),
    .var_assigned (var_assigned),
    .var_value    (var_value),
    .satisfied    (sat_w),
    .open_count   (open_w),
    .unit_var     (unit_var_w),
    .unit_val     (unit_val_w)
  );

  assign idx_inc = idx_q + IDX_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prop_var_q  <= '0;
      idx_q       <= '0;
      end_q       <= '0;
      conflict_q  <= 1'b0;
      imply_var_q <= '0;
      imply_val_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prop_var_q  <= prop_var_d;
      idx_q       <= idx_d;
      end_q       <= end_d;
      conflict_q  <= conflict_d;
      imply_var_q <= imply_var_d;
      imply_val_q <= imply_val_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prop_var_d  = prop_var_q;
    idx_d       = idx_q;
    end_d       = end_q;
    conflict_d  = conflict_q;
    imply_var_d = imply_var_q;
    imply_val_d = imply_val_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prop_var_d = prop_var;
          state_d    = S_RANGE;
        end
      end
      S_RANGE: begin
        idx_d   = {1'b0, range_start};
        end_d   = {1'b0, range_end};
        state_d = S_LOAD;
      end
      S_LOAD: begin
        conflict_d = 1'b0;
        state_d    = (idx_q >= end_q) ? S_DONE : S_READ;
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (!sat_w && open_w == 2'd0) begin
          conflict_d = 1'b1;
          state_d    = S_DONE;
        end else if (!sat_w && open_w == 2'd1) begin
          imply_var_d = unit_var_w;
          imply_val_d = unit_val_w;
          state_d     = S_PUSH;
        end else begin
          idx_d   = idx_inc;
          state_d = (idx_inc == end_q) ? S_DONE : S_READ;
        end
      end
      S_PUSH: begin
        if (!full_imply) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == end_q) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        conflict_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // range_addr bypasses prop_var_q on the start cycle so the table read
  // issued in IDLE returns its data in RANGE.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    conflict    = (state_q == S_DONE) && conflict_q;
    push_imply  = (state_q == S_PUSH) && !full_imply;
    range_addr  = (state_q == S_IDLE && start) ? prop_var : prop_var_q;
    clause_addr = idx_q[OCC_INDEX-1:0];
    imply_var   = imply_var_q;
    imply_val   = imply_val_q;
    imply_type  = TYPE_F;
  end

endmodule

// File: tb/tb_bcp_engine.sv
// Directed bench for bcp_engine with modelled range table and clause store.
module tb_bcp_engine;
  import sat_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      start;
  logic [VARIABLE_INDEX-1:0] prop_var;
  logic                      busy, done, conflict;
  logic [VARIABLE_INDEX-1:0] range_addr;
  logic [OCC_INDEX-1:0]      range_start, range_end;
  logic [OCC_INDEX-1:0]      clause_addr;
  logic [CLAUSE_W-1:0]       clause_data;
  logic [NUM_VARIABLE-1:0]   var_assigned, var_value;
  logic                      push_imply;
  logic [VARIABLE_INDEX-1:0] imply_var;
  logic                      imply_val, imply_type;
  logic                      full_imply;

  logic [OCC_INDEX-1:0] rs_mem [0:NUM_VARIABLE-1];
  logic [OCC_INDEX-1:0] re_mem [0:NUM_VARIABLE-1];
  logic [CLAUSE_W-1:0]  cmem   [0:1023];
  logic [7:0]           push_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  bcp_engine dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .prop_var     (prop_var),
    .busy         (busy),
    .done         (done),
    .conflict     (conflict),
    .range_addr   (range_addr),
    .range_start  (range_start),
    .range_end    (range_end),
    .clause_addr  (clause_addr),
    .clause_data  (clause_data),
    .var_assigned (var_assigned),
    .var_value    (var_value),
    .push_imply   (push_imply),
    .imply_var    (imply_var),
    .imply_val    (imply_val),
    .imply_type   (imply_type),
    .full_imply   (full_imply)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    range_start <= rs_mem[range_addr];
    range_end   <= re_mem[range_addr];
    clause_data <= cmem[clause_addr];
  end

  always @(negedge clock) begin
    if (push_imply) push_q.push_back({imply_val, imply_var});
  end

  function automatic logic [LIT_W-1:0] lit(input logic v, input logic p, input logic [6:0] id);
    return {v, p, id};
  endfunction

  function automatic logic [CLAUSE_W-1:0] mk(input logic [LIT_W-1:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 1024; i++) cmem[i] = '0;
    for (int i = 0; i < NUM_VARIABLE; i++) begin
      rs_mem[i] = '0;
      re_mem[i] = '0;
    end
    var_assigned = '0;
    var_value    = '0;
    push_q.delete();
  endtask

  // Leaves the bench one cycle after the start cycle (RANGE).
  task automatic start_run(input logic [6:0] v);
    step();
    start    = 1'b1;
    prop_var = v;
    step();
    start    = 1'b0;
  endtask

  // Cycles counted from the start cycle; lat=-1 when the budget expires.
  task automatic wait_done(input int lat0, input int limit, output int lat,
                           output logic conf, output int max_addr);
    bit fin;
    lat = lat0; conf = 1'b0; max_addr = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clock);
      if (lat >= 2 && int'(clause_addr) > max_addr) max_addr = int'(clause_addr);
      if (done) begin
        conf = conflict;
        fin  = 1'b1;
      end else if (lat >= limit) begin
        lat = -1;
        fin = 1'b1;
      end else begin
        step();
        lat++;
      end
    end
  endtask

  task automatic setup_unit();
    clear_tables();
    var_assigned[3] = 1'b1;
    var_value[3]    = 1'b0;
    rs_mem[3] = 10'd0;
    re_mem[3] = 10'd1;
    cmem[0] = mk(lit(1, 1, 3), lit(1, 0, 7), '0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; prop_var = '0; full_imply = 1'b0;
    clear_tables();
    step(); step();
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", conflict); end
    n_checks++; if (push_imply !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b want 0", push_imply); end
    n_checks++; if ({imply_val, imply_var} !== 8'h00) begin n_fail++; $display("FAIL reset_imply: got %h want 00", {imply_val, imply_var}); end
    n_checks++; if ({range_addr, clause_addr} !== 17'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", {range_addr, clause_addr}); end
    n_checks++; if (imply_type !== 1'b1) begin n_fail++; $display("FAIL imply_type: got %b want 1", imply_type); end
  endtask

  task automatic test_empty_range();
    int lat, ma; logic conf;
    clear_tables();
    rs_mem[20] = 10'd5;
    re_mem[20] = 10'd5;
    start_run(7'd20);
    wait_done(1, 20, lat, conf, ma);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL empty_latency: got %0d want 3", lat); end
    n_checks++; if (conf !== 1'b0) begin n_fail++; $display("FAIL empty_conflict: got %b want 0", conf); end
    n_checks++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL empty_push: got %0d want 0", push_q.size()); end
  endtask

  task automatic test_unit();
    int lat, ma; logic conf;
    setup_unit();
    start_run(7'd3);
    wait_done(1, 30, lat, conf, ma);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL unit_latency: got %0d want 6", lat); end
    n_checks++; if (conf !== 1'b0) begin n_fail++; $display("FAIL unit_conflict: got %b want 0", conf); end
    n_checks++; if (push_q.size() !== 1) begin n_fail++; $display("FAIL unit_push_count: got %0d want 1", push_q.size()); end
    else begin
      n_checks++; if (push_q[0] !== 8'h07) begin n_fail++; $display("FAIL unit_push_val: got %h want 07", push_q[0]); end
    end
  endtask

  task automatic test_conflict();
    int lat, ma; logic conf;
    clear_tables();
    var_assigned[3] = 1'b1;
    var_value[3]    = 1'b0;
    rs_mem[10] = 10'd0;
    re_mem[10] = 10'd3;
    cmem[0] = mk(lit(1, 0, 3), '0, '0, '0, '0);
    cmem[1] = mk(lit(1, 1, 3), '0, '0, '0, '0);
    cmem[2] = mk(lit(1, 1, 20), '0, '0, '0, '0);
    start_run(7'd10);
    wait_done(1, 30, lat, conf, ma);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL conflict_latency: got %0d want 7", lat); end
    n_checks++; if (conf !== 1'b1) begin n_fail++; $display("FAIL conflict_flag: got %b want 1", conf); end
    n_checks++; if (ma !== 1) begin n_fail++; $display("FAIL conflict_max_addr: got %0d want 1", ma); end
    n_checks++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL conflict_push: got %0d want 0", push_q.size()); end
  endtask

  task automatic test_all_invalid();
    int lat, ma; logic conf;
    clear_tables();
    rs_mem[11] = 10'd4;
    re_mem[11] = 10'd5;
    start_run(7'd11);
    wait_done(1, 30, lat, conf, ma);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL invalid_latency: got %0d want 5", lat); end
    n_checks++; if (conf !== 1'b1) begin n_fail++; $display("FAIL invalid_conflict: got %b want 1", conf); end
  endtask

  task automatic test_backpressure();
    int lat, ma; logic conf;
    setup_unit();
    full_imply = 1'b1;
    start_run(7'd3);
    step(); step(); step(); step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_checks++; if (push_imply !== 1'b0) begin n_fail++; $display("FAIL bp_push_held[%0d]: got %b want 0", k, push_imply); end
      n_checks++; if ({imply_val, imply_var} !== 8'h07) begin n_fail++; $display("FAIL bp_imply_stable[%0d]: got %h want 07", k, {imply_val, imply_var}); end
      step();
    end
    full_imply = 1'b0;
    wait_done(0, 30, lat, conf, ma);
    n_checks++; if (lat < 0) begin n_fail++; $display("FAIL bp_timeout: got %0d want done", lat); end
    n_checks++; if (conf !== 1'b0) begin n_fail++; $display("FAIL bp_conflict: got %b want 0", conf); end
    n_checks++; if (push_q.size() !== 1) begin n_fail++; $display("FAIL bp_push_count: got %0d want 1", push_q.size()); end
  endtask

  task automatic test_mixed();
    int lat, ma; logic conf;
    clear_tables();
    var_assigned[3] = 1'b1; var_value[3] = 1'b0;
    var_assigned[5] = 1'b1; var_value[5] = 1'b1;
    rs_mem[40] = 10'd0;
    re_mem[40] = 10'd4;
    cmem[0] = mk(lit(0, 1, 3), lit(1, 0, 3), lit(1, 1, 50), '0, '0);
    cmem[1] = mk(lit(1, 1, 30), lit(1, 0, 31), '0, '0, '0);
    cmem[2] = mk(lit(1, 1, 3), lit(1, 1, 9), '0, '0, '0);
    cmem[3] = mk(lit(1, 0, 12), lit(1, 0, 5), '0, '0, '0);
    start_run(7'd40);
    step(); step(); step();
    start = 1'b1; prop_var = 7'd99;
    step();
    start = 1'b0;
    wait_done(5, 40, lat, conf, ma);
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL mixed_latency: got %0d want 13", lat); end
    n_checks++; if (conf !== 1'b0) begin n_fail++; $display("FAIL mixed_conflict: got %b want 0", conf); end
    n_checks++; if (push_q.size() !== 2) begin n_fail++; $display("FAIL mixed_push_count: got %0d want 2", push_q.size()); end
    else begin
      n_checks++; if (push_q[0] !== 8'h89) begin n_fail++; $display("FAIL mixed_push0: got %h want 89", push_q[0]); end
      n_checks++; if (push_q[1] !== 8'h0c) begin n_fail++; $display("FAIL mixed_push1: got %h want 0c", push_q[1]); end
    end
    step();
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mixed_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat, ma; logic conf;
    setup_unit();
    full_imply = 1'b1;
    start_run(7'd3);
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if ({busy, done, conflict, push_imply} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0000", {busy, done, conflict, push_imply}); end
    n_checks++; if ({imply_val, imply_var} !== 8'h00) begin n_fail++; $display("FAIL rst_mid_imply: got %h want 00", {imply_val, imply_var}); end
    n_checks++; if ({range_addr, clause_addr} !== 17'h0) begin n_fail++; $display("FAIL rst_mid_addr: got %h want 0", {range_addr, clause_addr}); end
    n_checks++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_push: got %0d want 0", push_q.size()); end
    full_imply = 1'b0;
    start_run(7'd3);
    wait_done(1, 30, lat, conf, ma);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL rst_rerun_latency: got %0d want 6", lat); end
    n_checks++; if (push_q.size() !== 1) begin n_fail++; $display("FAIL rst_rerun_push: got %0d want 1", push_q.size()); end
  endtask

  initial begin
    test_reset();
    test_empty_range();
    test_unit();
    test_conflict();
    test_all_invalid();
    test_backpressure();
    test_mixed();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
